// File: rtl/current_adc_reader.sv
// Periodic 12-bit SPI current ADC reader with boxcar averaging.
// Every SAMPLE_PERIOD clocks one 16-SCLK frame is clocked in. The 12 data bits
// are accumulated, and every 2^AVG_LOG2 frames their floor average is published.
module current_adc_reader #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int AVG_LOG2      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adc_miso,
  output logic        adc_sclk,
  output logic        adc_cs_n,
  output logic [11:0] current_b_out,
  output logic        sample_valid,
  output logic        adc_busy
);

  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW = 12 + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, ACCUM} state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [DW-1:0]   div_cnt, div_nx;
  logic [3:0]      bit_cnt, bit_nx;
  logic [11:0]     sr, sr_nx;
  logic [AW-1:0]   acc, acc_nx, sum;
  logic [NW-1:0]   n_cnt, n_nx;
  logic            sclk_nx, cs_n_nx, valid_nx;
  logic [11:0]     out_nx;
  logic            div_last;

  assign tick     = (tick_cnt == TW'(SAMPLE_PERIOD - 1));
  assign div_last = (div_cnt == DW'(CLK_DIV - 1));
  assign adc_busy = (state == CS_SETUP) || (state == SHIFT) || (state == CS_HOLD);

  // Free-running conversion-start timer; never held off by a busy frame.
  always_ff @(posedge clk) begin
    if (rst || tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + 1'b1;
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_nx = state;
    div_nx   = div_cnt;
    bit_nx   = bit_cnt;
    sr_nx    = sr;
    acc_nx   = acc;
    n_nx     = n_cnt;
    sclk_nx  = adc_sclk;
    cs_n_nx  = adc_cs_n;
    out_nx   = current_b_out;
    valid_nx = 1'b0;
    sum      = acc + AW'(sr);
    case (state)
      IDLE: begin
        if (tick) begin
          state_nx = CS_SETUP;
          cs_n_nx  = 1'b0;
          div_nx   = '0;
        end
      end
      CS_SETUP: begin
        if (div_last) begin
          state_nx = SHIFT;
          div_nx   = '0;
          bit_nx   = '0;
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (div_last) begin
          div_nx = '0;
          if (!adc_sclk) begin
            sclk_nx = 1'b1;
            // Periods 4..15 (index 3..14) carry data MSB first; the rest are dropped.
            if (bit_cnt >= 4'd3 && bit_cnt <= 4'd14) sr_nx = {sr[10:0], adc_miso};
          end else begin
            sclk_nx = 1'b0;
            if (bit_cnt == 4'd15) begin
              state_nx = CS_HOLD;
              cs_n_nx  = 1'b1;
            end else begin
              bit_nx = bit_cnt + 1'b1;
            end
          end
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end
      CS_HOLD: begin
        if (div_last) begin
          state_nx = ACCUM;
          div_nx   = '0;
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end
      ACCUM: begin
        state_nx = IDLE;
        if (n_cnt == NW'((1 << AVG_LOG2) - 1)) begin
          out_nx   = 12'(sum >> AVG_LOG2);
          valid_nx = 1'b1;
          acc_nx   = '0;
          n_nx     = '0;
        end else begin
          acc_nx = sum;
          n_nx   = n_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      sr            <= '0;
      acc           <= '0;
      n_cnt         <= '0;
      adc_sclk      <= 1'b0;
      adc_cs_n      <= 1'b1;
      current_b_out <= '0;
      sample_valid  <= 1'b0;
    end else begin
      state         <= state_nx;
      div_cnt       <= div_nx;
      bit_cnt       <= bit_nx;
      sr            <= sr_nx;
      acc           <= acc_nx;
      n_cnt         <= n_nx;
      adc_sclk      <= sclk_nx;
      adc_cs_n      <= cs_n_nx;
      current_b_out <= out_nx;
      sample_valid  <= valid_nx;
    end
  end

endmodule

// File: tb/tb_current_adc_reader.sv
// Directed bench: two readers (averaging x4 at 100-cycle period, and
// pass-through at a too-short 60-cycle period) driven by ADC models.
module tb_current_adc_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, miso_a, miso_b;
  logic        sclk_a, cs_n_a, valid_a, busy_a;
  logic        sclk_b, cs_n_b, valid_b, busy_b;
  logic [11:0] out_a, out_b;

  int checks = 0;
  int errors = 0;

  current_adc_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(100), .AVG_LOG2(2)) dut_a (
    .clk(clk), .rst(rst_a), .adc_miso(miso_a), .adc_sclk(sclk_a), .adc_cs_n(cs_n_a),
    .current_b_out(out_a), .sample_valid(valid_a), .adc_busy(busy_a));

  current_adc_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(60), .AVG_LOG2(0)) dut_b (
    .clk(clk), .rst(rst_b), .adc_miso(miso_b), .adc_sclk(sclk_b), .adc_cs_n(cs_n_b),
    .current_b_out(out_b), .sample_valid(valid_b), .adc_busy(busy_b));

  // ADC A model and frame measurements
  logic [15:0] word_a;
  logic        psclk_a = 1'b0, pcs_a = 1'b1, pbusy_a = 1'b0;
  logic [11:0] pout_a = '0;
  int idx_a = 0, rises_a = 0, low_a = 0, busyc_a = 0;
  int last_rises_a = 0, last_low_a = 0, last_busy_a = 0;
  int frames_a = 0, vcnt_a = 0, badchg_a = 0, cyc_a = 0, first_fall_a = -1;

  always @(posedge clk) begin
    if (rst_a) cyc_a = 0;
    else       cyc_a++;
  end

  always @(negedge clk) begin
    if (cs_n_a) begin
      miso_a = word_a[15];
      idx_a  = 0;
      if (!pcs_a) begin
        last_rises_a = rises_a;
        last_low_a   = low_a;
        frames_a++;
      end
    end else begin
      if (pcs_a) begin
        rises_a = 0;
        low_a   = 0;
        if (first_fall_a < 0) first_fall_a = cyc_a;
      end
      low_a++;
      if (sclk_a && !psclk_a) rises_a++;
      if (!sclk_a && psclk_a && idx_a < 15) begin
        idx_a++;
        miso_a = word_a[15 - idx_a];
      end
    end
    if (busy_a && !pbusy_a) busyc_a = 0;
    if (busy_a) busyc_a++;
    if (!busy_a && pbusy_a) last_busy_a = busyc_a;
    if (valid_a) vcnt_a++;
    if (out_a !== pout_a && !valid_a) badchg_a++;
    pout_a  = out_a;
    psclk_a = sclk_a;
    pcs_a   = cs_n_a;
    pbusy_a = busy_a;
  end

  // ADC B model and frame spacing measurements
  logic [15:0] word_b;
  logic        psclk_b = 1'b0, pcs_b = 1'b1;
  logic [11:0] pout_b = '0;
  int idx_b = 0, low_b = 0, high_b = 0, since_b = 0;
  int frames_b = 0, starts_b = 0, vcnt_b = 0, badchg_b = 0;
  int last_period_b = 0, min_high_b = 1000000, max_low_b = 0;

  always @(negedge clk) begin
    since_b++;
    if (cs_n_b) begin
      miso_b = word_b[15];
      idx_b  = 0;
      high_b++;
      if (!pcs_b) begin
        if (low_b > max_low_b) max_low_b = low_b;
        frames_b++;
        high_b = 1;
      end
    end else begin
      if (pcs_b) begin
        if (starts_b > 0) begin
          last_period_b = since_b;
          if (high_b < min_high_b) min_high_b = high_b;
        end
        since_b = 0;
        starts_b++;
        low_b = 0;
      end
      low_b++;
      if (!sclk_b && psclk_b && idx_b < 15) begin
        idx_b++;
        miso_b = word_b[15 - idx_b];
      end
    end
    if (valid_b) vcnt_b++;
    if (out_b !== pout_b && !valid_b) badchg_b++;
    pout_b  = out_b;
    psclk_b = sclk_b;
    pcs_b   = cs_n_b;
  end

  function automatic logic [15:0] mk(input logic [2:0] disc, input logic [11:0] data, input logic last);
    return {disc, data, last};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Load the next frame's word and wait for that frame to end.
  task automatic a_frame(input logic [15:0] w);
    int f0;
    int n;
    word_a = w;
    f0 = frames_a;
    n = 0;
    while (frames_a == f0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("frame_done", 32'(frames_a != f0), 32'd1);
  endtask

  task automatic wait_valid_a(input int v0);
    int n;
    n = 0;
    while (vcnt_a == v0 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int v0;
    int n;
    rst_a  = 1'b1;
    rst_b  = 1'b1;
    word_a = '0;
    word_b = mk(3'b000, 12'hA5C, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_n_a), 32'd1);
    check("rst_sclk", 32'(sclk_a), 32'd0);
    check("rst_out", 32'(out_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Constant 2500 for four frames
    repeat (4) a_frame(mk(3'b000, 12'd2500, 1'b0));
    wait_valid_a(0);
    repeat (5) @(negedge clk);
    check("first_tick_cycle", 32'(first_fall_a), 32'd100);
    check("const_vcnt", 32'(vcnt_a), 32'd1);
    check("const_out", 32'(out_a), 32'd2500);
    check("sclk_rises", 32'(last_rises_a), 32'd16);
    check("cs_low_cycles", 32'(last_low_a), 32'd66);
    check("busy_cycles", 32'(last_busy_a), 32'd68);

    // 100..103 averages to 101 (406>>2)
    for (int i = 0; i < 4; i++) a_frame(mk(3'b000, 12'(100 + i), 1'b0));
    wait_valid_a(1);
    @(negedge clk);
    check("avg_vcnt", 32'(vcnt_a), 32'd2);
    check("avg_out", 32'(out_a), 32'd101);

    // Full scale, no overflow
    repeat (4) a_frame(mk(3'b000, 12'hFFF, 1'b0));
    wait_valid_a(2);
    @(negedge clk);
    check("max_out", 32'(out_a), 32'd4095);

    // Discarded bits all ones, data zero
    repeat (4) a_frame(mk(3'b111, 12'd0, 1'b1));
    wait_valid_a(3);
    @(negedge clk);
    check("discard_out", 32'(out_a), 32'd0);
    check("discard_vcnt", 32'(vcnt_a), 32'd4);

    // Two frames of 1000, then reset in the middle of the third
    repeat (2) a_frame(mk(3'b000, 12'd1000, 1'b0));
    n = 0;
    while (!(cs_n_a == 1'b0 && rises_a >= 5) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("reached_shift", 32'(rises_a >= 5 && cs_n_a == 1'b0), 32'd1);
    rst_a = 1'b1;
    @(negedge clk);
    check("abort_cs_n", 32'(cs_n_a), 32'd1);
    check("abort_sclk", 32'(sclk_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    rst_a = 1'b0;
    repeat (3) @(negedge clk);
    v0 = vcnt_a;
    repeat (3) a_frame(mk(3'b000, 12'd3000, 1'b0));
    repeat (10) @(negedge clk);
    check("abort_no_early_valid", 32'(vcnt_a), 32'(v0));
    a_frame(mk(3'b000, 12'd3000, 1'b0));
    wait_valid_a(v0);
    @(negedge clk);
    check("abort_vcnt", 32'(vcnt_a), 32'(v0 + 1));
    check("abort_out", 32'(out_a), 32'd3000);
    check("a_out_only_on_valid", 32'(badchg_a), 32'd0);

    // Reader B: pass-through, short period
    v0 = starts_b;
    n = 0;
    while (starts_b == v0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("b_frame_seen", 32'(starts_b != v0), 32'd1);
    check("b_many_frames", 32'(frames_b >= 10), 32'd1);
    check("b_valid_per_frame", 32'(vcnt_b), 32'(frames_b));
    check("b_out", 32'(out_b), 32'hA5C);
    check("b_period", 32'(last_period_b), 32'd120);
    check("b_min_high", 32'(min_high_b), 32'd54);
    check("b_max_low", 32'(max_low_b), 32'd66);
    check("b_out_only_on_valid", 32'(badchg_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/current_adc_reader.md
CURRENT_ADC_READER -- requirements
Module: current_adc_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles, minimum 1.
REQ-002 SHALL have parameter SAMPLE_PERIOD, default 1000: clk cycles between conversion starts, minimum 34*CLK_DIV+3.
REQ-003 SHALL have parameter AVG_LOG2, default 2: log2 of the number of samples averaged per output (default 4 samples), range 0..4.
REQ-004 SHALL have port clk  input  1  system clock; all logic is clocked on the rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port adc_miso  input  1  serial data from the 12-bit SPI current ADC.
REQ-007 SHALL have port adc_sclk  output  1  SPI clock, registered, idle low.
REQ-008 SHALL have port adc_cs_n  output  1  ADC chip select, registered, active-low.
REQ-009 SHALL have port current_b_out  output  12  averaged current code, unsigned, held between updates; this feeds the overcurrent monitor directly.
REQ-010 SHALL have port sample_valid  output  1  one-cycle pulse when current_b_out updates.
REQ-011 SHALL have port adc_busy  output  1  high while a frame is in progress (adc_cs_n low or CS_SETUP/CS_HOLD active).

Function
REQ-012 SHALL run a free-running tick counter 0..SAMPLE_PERIOD-1 with wrap-around; tick is asserted when count == SAMPLE_PERIOD-1.
REQ-013 SHALL implement FSM states IDLE, CS_SETUP, SHIFT, CS_HOLD, ACCUM.
REQ-014 IDLE: on tick, go to CS_SETUP; adc_cs_n falls on the same edge that leaves IDLE.
REQ-015 CS_SETUP: hold adc_cs_n=0 and adc_sclk=0 for CLK_DIV cycles, then go to SHIFT.
REQ-016 SHIFT: generate exactly 16 SCLK periods, each with CLK_DIV cycles low followed by CLK_DIV cycles high.
REQ-017 SHIFT: sample adc_miso on the clk edge where adc_sclk is driven 0->1; bits 1-3 are discarded, bits 4-15 are data MSB first, bit 16 is ignored.
REQ-018 SHIFT to CS_HOLD: adc_sclk=0 and adc_cs_n=1 on entry; CS_HOLD lasts CLK_DIV cycles, then goes to ACCUM.
REQ-019 The total adc_cs_n low time per frame SHALL be exactly 33*CLK_DIV cycles.
REQ-020 ACCUM (1 cycle): add the 12-bit sample to an accumulator of width 12+AVG_LOG2 (no overflow possible) and increment the sample count, then return to IDLE.
REQ-021 When the sample count reaches 2^AVG_LOG2, ACCUM SHALL register current_b_out = accumulator_sum >> AVG_LOG2 (floor, truncation), pulse sample_valid for 1 cycle, and clear the accumulator and count.
REQ-022 sample_valid SHALL assert on the edge that leaves ACCUM; latency is 1 cycle from the final accumulation.
REQ-023 A tick arriving while the FSM is not in IDLE SHALL be dropped, with no queuing; the tick counter is not disturbed.
REQ-024 AVG_LOG2=0 SHALL pass each frame's sample straight to the output with a valid pulse per frame.
REQ-025 current_b_out SHALL change only on a sample_valid cycle.

Reset
REQ-026 While rst=1 at a clk edge: adc_cs_n=1, adc_sclk=0, current_b_out=0, sample_valid=0, adc_busy=0, FSM=IDLE, tick counter=0, accumulator=0, sample count=0, shift register=0.
REQ-027 Reset during a frame SHALL abort it: adc_cs_n=1 on that edge, the partial sample is discarded, and no sample_valid is produced.
REQ-028 The first tick after rst deasserts SHALL occur SAMPLE_PERIOD-1 cycles after the first non-reset edge.

Verification (CLK_DIV=2, SAMPLE_PERIOD=100, AVG_LOG2=2, behavioural ADC model driving miso on falling SCLK)
REQ-029 Constant ADC code 12'd2500 for 4 frames -> exactly one sample_valid pulse, current_b_out=2500; each frame shows 16 SCLK rises and 66 cycles of adc_cs_n low.
REQ-030 Codes 100, 101, 102, 103 -> current_b_out=101 (406>>2, truncated); a further 4x 4095 -> 4095 with no overflow.
REQ-031 miso=1 on discarded bits 1-3 and 16, data=0 -> current_b_out=0; data=12'hA5C with discard bits 0 -> 12'hA5C with AVG_LOG2=0.
REQ-032 rst pulsed for 1 cycle mid-SHIFT after 2 completed frames -> adc_cs_n=1 and adc_sclk=0 on the next edge, no sample_valid; the next sample_valid occurs only after 4 fresh frames.
REQ-033 SAMPLE_PERIOD=60 (below the minimum) -> the tick arriving while busy is dropped, frames never overlap, and adc_cs_n high time between frames is at least CLK_DIV+1 cycles.
